sync_fifo_ctrl: RTL and testbench

//  Single-clock, parametrised FIFO for intra-domain buffering. Next generation of the

---
 rtl/sync_fifo_ctrl.sv | 102 ++++++++++
 tb/tb_sync_fifo_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with standard or first-word-fall-through read, programmable
// almost-full/almost-empty levels, occupancy count, flush and sticky error flags.
`timescale 1ns/1ps
module sync_fifo_ctrl #(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 4,
   parameter int FWFT      = 0,
   parameter int AF_LEVEL  = 14,
   parameter int AE_LEVEL  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_SIZE-1:0] w_data,
   input  logic                 w_inc,
   input  logic                 r_inc,
   input  logic                 flush,
   output logic [DATA_SIZE-1:0] r_data,
   output logic                 w_full,
   output logic                 r_empty,
   output logic                 w_almost_full,
   output logic                 r_almost_empty,
   output logic [ADDR_SIZE:0]   count,
   output logic                 overflow,
   output logic                 underflow
);
   localparam int DEPTH = 1 << ADDR_SIZE;
   localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(DEPTH);
   localparam logic [ADDR_SIZE:0] AF_C    = (ADDR_SIZE+1)'(AF_LEVEL);
   localparam logic [ADDR_SIZE:0] AE_C    = (ADDR_SIZE+1)'(AE_LEVEL);

   logic [DATA_SIZE-1:0] mem [DEPTH];
   logic [ADDR_SIZE:0]   wptr, rptr, wptr_nxt, rptr_nxt, count_nxt;
   logic                 rd_ok, wr_ok, mem_empty, mem_wr, mem_rd;
   logic                 load_out, bypass, ovalid, ovalid_nxt;
   logic                 ovf_set, unf_set;

   always_comb begin
      rd_ok     = ~flush & r_inc & ~r_empty;
      wr_ok     = ~flush & w_inc & (~w_full | rd_ok);
      ovf_set   = ~flush & w_inc & ~wr_ok;
      unf_set   = ~flush & r_inc & r_empty;
      mem_empty = (wptr == rptr);
      load_out  = 1'b0;
      bypass    = 1'b0;
      mem_wr    = wr_ok;
      mem_rd    = rd_ok;
      if (FWFT != 0) begin
         // Output register is refilled whenever it is free; an empty store lets the
         // incoming word skip memory and land straight in the output register.
         load_out = ~flush & (~ovalid | rd_ok) & (~mem_empty | wr_ok);
         bypass   = load_out & mem_empty;
         mem_wr   = wr_ok & ~bypass;
         mem_rd   = load_out & ~mem_empty;
      end else begin
         load_out = rd_ok;
      end

      if (flush) begin
         wptr_nxt   = '0;
         rptr_nxt   = '0;
         count_nxt  = '0;
         ovalid_nxt = 1'b0;
      end else begin
         wptr_nxt   = wptr + {{ADDR_SIZE{1'b0}}, mem_wr};
         rptr_nxt   = rptr + {{ADDR_SIZE{1'b0}}, mem_rd};
         count_nxt  = count + {{ADDR_SIZE{1'b0}}, wr_ok} - {{ADDR_SIZE{1'b0}}, rd_ok};
         ovalid_nxt = load_out ? 1'b1 : (rd_ok ? 1'b0 : ovalid);
      end
   end

   always_ff @(posedge clk) begin
      if (mem_wr) mem[wptr[ADDR_SIZE-1:0]] <= w_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr           <= '0;
         rptr           <= '0;
         count          <= '0;
         ovalid         <= 1'b0;
         r_data         <= '0;
         w_full         <= 1'b0;
         r_empty        <= 1'b1;
         w_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
         overflow       <= 1'b0;
         underflow      <= 1'b0;
      end else begin
         wptr           <= wptr_nxt;
         rptr           <= rptr_nxt;
         count          <= count_nxt;
         ovalid         <= ovalid_nxt;
         if (load_out) r_data <= bypass ? w_data : mem[rptr[ADDR_SIZE-1:0]];
         w_full         <= (count_nxt == DEPTH_C);
         r_empty        <= (count_nxt == '0);
         w_almost_full  <= (count_nxt >= AF_C);
         r_almost_empty <= (count_nxt <= AE_C);
         overflow       <= ~flush & (overflow | ovf_set);
         underflow      <= ~flush & (underflow | unf_set);
      end
   end
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed scoreboard bench for sync_fifo_ctrl; standard and FWFT instances share stimulus.
`timescale 1ns/1ps
module tb_sync_fifo_ctrl;
   logic       clk = 1'b0;
   logic       rst_n, w_inc, r_inc, flush;
   logic [7:0] w_data;
   logic [7:0] r_data_s, r_data_f;
   logic       full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
   logic       full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
   logic [4:0] count_s, count_f;

   int         n_chk = 0, n_pass = 0;
   int         m_count;
   bit         m_ovf, m_unf;
   logic [7:0] exp_s[$], exp_f[$];

   always #5 clk = ~clk;

   sync_fifo_ctrl #(.DATA_SIZE(8), .ADDR_SIZE(4), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) u_std (
      .clk(clk), .rst_n(rst_n), .w_data(w_data), .w_inc(w_inc), .r_inc(r_inc), .flush(flush),
      .r_data(r_data_s), .w_full(full_s), .r_empty(empty_s), .w_almost_full(af_s),
      .r_almost_empty(ae_s), .count(count_s), .overflow(ovf_s), .underflow(unf_s));

   sync_fifo_ctrl #(.DATA_SIZE(8), .ADDR_SIZE(4), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) u_fwft (
      .clk(clk), .rst_n(rst_n), .w_data(w_data), .w_inc(w_inc), .r_inc(r_inc), .flush(flush),
      .r_data(r_data_f), .w_full(full_f), .r_empty(empty_f), .w_almost_full(af_f),
      .r_almost_empty(ae_f), .count(count_f), .overflow(ovf_f), .underflow(unf_f));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, req);
   endtask

   // status vector: {count, full, empty, almost_full, almost_empty, overflow, underflow}
   task automatic check_status(input string tag);
      logic [10:0] req;
      req = {5'(m_count), m_count == 16, m_count == 0, m_count >= 14, m_count <= 2, m_ovf, m_unf};
      chk({tag, "_std"},  {count_s, full_s, empty_s, af_s, ae_s, ovf_s, unf_s}, req);
      chk({tag, "_fwft"}, {count_f, full_f, empty_f, af_f, ae_f, ovf_f, unf_f}, req);
   endtask

   task automatic model_clear();
      m_count = 0; m_ovf = 0; m_unf = 0;
      exp_s.delete(); exp_f.delete();
   endtask

   task automatic step(input string tag, input bit w, input bit r, input logic [7:0] d, input bit fl);
      bit rd_ok, wr_ok;
      w_inc = w; r_inc = r; w_data = d; flush = fl;
      if (fl) model_clear();
      else begin
         rd_ok = r && (m_count != 0);
         wr_ok = w && ((m_count != 16) || rd_ok);
         if (w && !wr_ok) m_ovf = 1;
         if (r && m_count == 0) m_unf = 1;
         if (wr_ok) begin exp_s.push_back(d); exp_f.push_back(d); end
         m_count = m_count + int'(wr_ok) - int'(rd_ok);
      end
      @(posedge clk); #1;
      check_status(tag);
   endtask

   // Monitor: standard mode word appears one clock after the accepted pop; FWFT head
   // is compared whenever the output is valid and retired on an accepted pop.
   initial begin
      bit         pend;
      logic [7:0] held;
      pend = 0;
      held = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) pend = 0;
         else begin
            if (pend) chk("rdata_std", r_data_s, held);
            pend = 0;
            if (r_inc && !empty_s && !flush) begin
               if (exp_s.size() == 0) begin
                  n_chk++;
                  $display("FAIL sb_std: DUT popped with no word expected, r_data %0h", r_data_s);
               end else begin
                  held = exp_s.pop_front();
                  pend = 1;
               end
            end
            if (!empty_f && !flush) begin
               if (exp_f.size() == 0) begin
                  n_chk++;
                  $display("FAIL sb_fwft: output valid with no word expected, r_data %0h", r_data_f);
               end else begin
                  chk("rdata_fwft", r_data_f, exp_f[0]);
                  if (r_inc) void'(exp_f.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; w_inc = 0; r_inc = 0; flush = 0; w_data = '0;
      model_clear();
      #12;
      check_status("reset");
      chk("reset_rdata_std", r_data_s, 8'h00);
      chk("reset_rdata_fwft", r_data_f, 8'h00);
      @(posedge clk); #1; rst_n = 1'b1;

      // fill 0x01..0x10, then drain in order, then one read too many
      for (int i = 1; i <= 16; i++) step("fill", 1, 0, 8'(i), 0);
      for (int i = 0; i < 16; i++) step("drain", 0, 1, 8'h00, 0);
      step("underflow", 0, 1, 8'h00, 0);
      chk("rdata_hold_std", r_data_s, 8'h10);
      chk("rdata_hold_fwft", r_data_f, 8'h10);
      step("flush1", 0, 0, 8'h00, 1);

      // full with simultaneous write/read, then a rejected write
      for (int i = 1; i <= 16; i++) step("refill", 1, 0, 8'(i), 0);
      step("full_wr_rd", 1, 1, 8'hAA, 0);
      step("overflow", 1, 0, 8'hBB, 0);
      for (int i = 0; i < 16; i++) step("drain2", 0, 1, 8'h00, 0);

      // empty with simultaneous write/read; FWFT shows a word without a pop
      step("empty_wr_rd", 1, 1, 8'h33, 0);
      chk("fwft_fallthrough_33", r_data_f, 8'h33);
      step("pop33", 0, 1, 8'h00, 0);
      step("flush2", 0, 0, 8'h00, 1);
      step("wr5a", 1, 0, 8'h5A, 0);
      chk("fwft_fallthrough_5a", r_data_f, 8'h5A);
      chk("std_hold_33", r_data_s, 8'h33);
      step("pop5a", 0, 1, 8'h00, 0);

      // interleaved traffic: 40 writes wrap the pointers twice
      for (int i = 0; i < 60; i++) step("mix", (i % 3) != 2, (i % 2) == 1, 8'(i + 128), 0);
      for (int i = 0; i < 12; i++) step("mix_drain", 0, 1, 8'h00, 0);

      // flush with both error flags set at count 9
      step("flush3", 0, 0, 8'h00, 1);
      step("set_unf", 0, 1, 8'h00, 0);
      for (int i = 0; i < 16; i++) step("fill3", 1, 0, 8'(8'h40 + i), 0);
      step("set_ovf", 1, 0, 8'hEE, 0);
      for (int i = 0; i < 7; i++) step("to_nine", 0, 1, 8'h00, 0);
      chk("count_nine", count_s, 5'd9);
      step("flush_at_9", 0, 0, 8'h00, 1);

      // asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) step("prereset", 1, 0, 8'(8'h61 + i), 0);
      step("idle", 0, 0, 8'h00, 0);
      rst_n = 1'b0;
      model_clear();
      #2;
      check_status("async_reset");
      chk("async_reset_rdata_std", r_data_s, 8'h00);
      chk("async_reset_rdata_fwft", r_data_f, 8'h00);
      @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
      step("post_reset_wr", 1, 0, 8'h77, 0);
      chk("post_reset_fwft", r_data_f, 8'h77);
      step("post_reset_rd", 0, 1, 8'h00, 0);
      step("final_idle", 0, 0, 8'h00, 0);
      chk("sb_left_std", exp_s.size(), 0);
      chk("sb_left_fwft", exp_f.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
